// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding IM request FSM feeding a small
// two-entry {pc, instr} queue towards decode, with redirect (flush) support.
module fetch_unit #(
   parameter int unsigned QDEPTH   = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PC,
   output logic        pc_hold,
   input  logic        flush,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CW = $clog2(QDEPTH + 1);

   if (QDEPTH != 2 || RESET_PC[1:0] != 2'b00) begin : g_bad_cfg
      $error("fetch_unit: QDEPTH must be 2 and RESET_PC word aligned");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [31:0]   mem_pc_q  [QDEPTH];
   logic [31:0]   mem_ins_q [QDEPTH];

   logic issue;
   logic push;
   logic pop;
   logic has_room;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Reset gates the handshake outputs so nothing leaks while held.
   assign has_room = (count_q < CW'(QDEPTH));
   assign im_req   = !Reset && (state_q == IDLE) && has_room && !flush;
   assign im_addr  = PC;
   assign issue    = im_req && im_ack;
   assign pc_hold  = Reset || !(issue || flush);

   assign instr_valid = (count_q != '0);
   assign instr       = instr_valid ? mem_ins_q[head_q] : 32'h0;
   assign instr_pc    = instr_valid ? mem_pc_q[head_q]  : 32'h0;
   assign pop         = instr_valid && instr_ready && !flush;

   always_comb begin
      state_d  = state_q;
      req_pc_d = req_pc_q;
      push     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (issue) begin
               state_d  = WAIT;
               req_pc_d = PC;
            end
         end
         WAIT: begin
            if (im_rvalid) begin
               state_d = IDLE;
               push    = !flush;
            end else if (flush) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (im_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         count_d = '0;
         head_d  = '0;
         tail_d  = '0;
      end else begin
         if (push) tail_d = ptr_inc(tail_q);
         if (pop)  head_d = ptr_inc(head_q);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         req_pc_q <= 32'h0;
         count_q  <= '0;
         head_q   <= '0;
         tail_q   <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
         count_q  <= count_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            mem_pc_q[i]  <= 32'h0;
            mem_ins_q[i] <= 32'h0;
         end
      end else if (push) begin
         mem_pc_q[tail_q]  <= req_pc_q;
         mem_ins_q[tail_q] <= im_rdata;
      end
   end

   a_one_outstanding: assert property (
      @(posedge Clk) disable iff (Reset) (state_q != IDLE) |-> !im_req);

   a_no_overflow: assert property (
      @(posedge Clk) disable iff (Reset) push |-> has_room);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch, full queue, flush paths,
// simultaneous push/pop with pointer wrap, and mid-cycle async reset.
module tb_fetch_unit;

   localparam logic [31:0] RPC = 32'h0000_3000;

   logic        Clk;
   logic        Reset;
   logic [31:0] PC;
   logic        pc_hold;
   logic        flush;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic        im_rvalid;
   logic [31:0] im_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.QDEPTH(2), .RESET_PC(RPC)) dut (
      .Clk(Clk), .Reset(Reset), .PC(PC), .pc_hold(pc_hold),
      .flush(flush), .im_req(im_req), .im_addr(im_addr),
      .im_ack(im_ack), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; PC = RPC; flush = 1'b0; im_ack = 1'b1;
      im_rvalid = 1'b0; im_rdata = 32'h0; instr_ready = 1'b0;
      tick(); #1;
      checks++; if (im_req !== 1'b0) begin errors++;
         $display("FAIL rst_im_req got %0b exp 0", im_req); end
      checks++; if (pc_hold !== 1'b1) begin errors++;
         $display("FAIL rst_pc_hold got %0b exp 1", pc_hold); end
      checks++; if (instr_valid !== 1'b0) begin errors++;
         $display("FAIL rst_valid got %0b exp 0", instr_valid); end
      checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++;
         $display("FAIL rst_head got %h/%h exp 0/0", instr_pc, instr); end
      checks++; if (im_addr !== 32'h3000) begin errors++;
         $display("FAIL rst_im_addr got %h exp 3000", im_addr); end
      im_ack = 1'b0;
      tick();
      Reset = 1'b0; #1;
      checks++; if (im_req !== 1'b1) begin errors++;
         $display("FAIL post_rst_im_req got %0b exp 1", im_req); end
   endtask

   task automatic test_basic_fetch();
      instr_ready = 1'b1; PC = 32'h3000; im_ack = 1'b1; #1;
      checks++; if (pc_hold !== 1'b0 || im_addr !== 32'h3000) begin errors++;
         $display("FAIL basic_ack got hold=%0b addr=%h exp 0/3000", pc_hold, im_addr); end
      tick();
      im_ack = 1'b0; PC = 32'h3004; im_rvalid = 1'b1; im_rdata = 32'h2401_0001; #1;
      checks++; if (im_req !== 1'b0 || pc_hold !== 1'b1 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_wait got req=%0b hold=%0b v=%0b exp 0/1/0",
                  im_req, pc_hold, instr_valid); end
      tick();
      im_rvalid = 1'b0; #1;
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h2401_0001 ||
                    instr_pc !== 32'h3000) begin errors++;
         $display("FAIL basic_head got v=%0b %h/%h exp 1 3000/24010001",
                  instr_valid, instr_pc, instr); end
      checks++; if (im_req !== 1'b1 || im_addr !== 32'h3004) begin errors++;
         $display("FAIL basic_next_req got %0b %h exp 1 3004", im_req, im_addr); end
      tick(); #1;
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++;
         $display("FAIL basic_pop got v=%0b %h exp 0 0", instr_valid, instr); end
   endtask

   task automatic test_full_queue();
      instr_ready = 1'b0; PC = 32'h3000; im_ack = 1'b1;
      tick();
      im_ack = 1'b0; PC = 32'h3004; im_rvalid = 1'b1; im_rdata = 32'hAAAA_0001;
      tick();
      im_rvalid = 1'b0; im_ack = 1'b1; #1;
      checks++; if (pc_hold !== 1'b0) begin errors++;
         $display("FAIL full_second_ack hold got %0b exp 0", pc_hold); end
      tick();
      im_ack = 1'b0; PC = 32'h3008; im_rvalid = 1'b1; im_rdata = 32'hBBBB_0002;
      tick();
      im_rvalid = 1'b0; im_ack = 1'b1; #1;
      checks++; if (im_req !== 1'b0 || pc_hold !== 1'b1) begin errors++;
         $display("FAIL full_stall got req=%0b hold=%0b exp 0/1", im_req, pc_hold); end
      checks++; if (instr_pc !== 32'h3000 || instr !== 32'hAAAA_0001) begin errors++;
         $display("FAIL full_head got %h/%h exp 3000/aaaa0001", instr_pc, instr); end
      im_ack = 1'b0; instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0; #1;
      checks++; if (instr_pc !== 32'h3004 || instr !== 32'hBBBB_0002) begin errors++;
         $display("FAIL full_after_pop got %h/%h exp 3004/bbbb0002", instr_pc, instr); end
      checks++; if (im_req !== 1'b1 || im_addr !== 32'h3008) begin errors++;
         $display("FAIL full_resume got %0b %h exp 1 3008", im_req, im_addr); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0; #1;
      checks++; if (instr_valid !== 1'b0) begin errors++;
         $display("FAIL full_drain got %0b exp 0", instr_valid); end
   endtask

   task automatic test_flush_wait();
      PC = 32'h3000; im_ack = 1'b1;
      tick();
      im_ack = 1'b0; flush = 1'b1; #1;
      checks++; if (pc_hold !== 1'b0 || im_req !== 1'b0) begin errors++;
         $display("FAIL fw_flush got hold=%0b req=%0b exp 0/0", pc_hold, im_req); end
      tick();
      flush = 1'b0; PC = 32'h4000;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (im_req !== 1'b0 || pc_hold !== 1'b1) begin errors++;
            $display("FAIL fw_drop_%0d got req=%0b hold=%0b exp 0/1", i, im_req, pc_hold); end
         tick();
      end
      im_rvalid = 1'b1; im_rdata = 32'hDEAD_BEEF; #1;
      checks++; if (im_req !== 1'b0) begin errors++;
         $display("FAIL fw_drop_rv req got %0b exp 0", im_req); end
      tick();
      im_rvalid = 1'b0; #1;
      checks++; if (instr_valid !== 1'b0) begin errors++;
         $display("FAIL fw_discard got %0b exp 0", instr_valid); end
      checks++; if (im_req !== 1'b1 || im_addr !== 32'h4000) begin errors++;
         $display("FAIL fw_redirect got %0b %h exp 1 4000", im_req, im_addr); end
      im_ack = 1'b1;
      tick();
      im_ack = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h1111_4000;
      tick();
      im_rvalid = 1'b0; #1;
      checks++; if (instr_pc !== 32'h4000 || instr !== 32'h1111_4000) begin errors++;
         $display("FAIL fw_refetch got %h/%h exp 4000/11114000", instr_pc, instr); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic test_flush_rvalid();
      PC = 32'h5000; im_ack = 1'b1;
      tick();
      im_ack = 1'b0; im_rvalid = 1'b1; im_rdata = 32'hD1D1_D1D1;
      tick();
      im_rvalid = 1'b0; PC = 32'h5004; im_ack = 1'b1;
      tick();
      im_ack = 1'b0; flush = 1'b1; im_rvalid = 1'b1; im_rdata = 32'hD2D2_D2D2; #1;
      checks++; if (pc_hold !== 1'b0 || instr_valid !== 1'b1) begin errors++;
         $display("FAIL frv_same got hold=%0b v=%0b exp 0/1", pc_hold, instr_valid); end
      tick();
      flush = 1'b0; im_rvalid = 1'b0; PC = 32'h8000; #1;
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++;
         $display("FAIL frv_empty got v=%0b %h exp 0 0", instr_valid, instr); end
      checks++; if (im_req !== 1'b1 || im_addr !== 32'h8000) begin errors++;
         $display("FAIL frv_idle got %0b %h exp 1 8000", im_req, im_addr); end
   endtask

   task automatic test_back_to_back();
      instr_ready = 1'b0; PC = 32'h6000; im_ack = 1'b1;
      tick();
      im_ack = 1'b0; im_rvalid = 1'b1; im_rdata = 32'hE1E1_0000;
      tick();
      im_rvalid = 1'b0; PC = 32'h6004; im_ack = 1'b1;
      tick();
      im_ack = 1'b0; im_rvalid = 1'b1; im_rdata = 32'hE2E2_0000; instr_ready = 1'b1; #1;
      checks++; if (instr_pc !== 32'h6000) begin errors++;
         $display("FAIL b2b_pre got %h exp 6000", instr_pc); end
      tick();
      im_rvalid = 1'b0; instr_ready = 1'b0; #1;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h6004 ||
                    instr !== 32'hE2E2_0000) begin errors++;
         $display("FAIL b2b_1 got v=%0b %h/%h exp 1 6004/e2e20000",
                  instr_valid, instr_pc, instr); end
      checks++; if (im_req !== 1'b1) begin errors++;
         $display("FAIL b2b_count got req=%0b exp 1", im_req); end
      PC = 32'h6008; im_ack = 1'b1;
      tick();
      im_ack = 1'b0; im_rvalid = 1'b1; im_rdata = 32'hE3E3_0000; instr_ready = 1'b1;
      tick();
      im_rvalid = 1'b0; instr_ready = 1'b0; #1;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h6008 ||
                    instr !== 32'hE3E3_0000) begin errors++;
         $display("FAIL b2b_wrap got v=%0b %h/%h exp 1 6008/e3e30000",
                  instr_valid, instr_pc, instr); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0; #1;
      checks++; if (instr_valid !== 1'b0) begin errors++;
         $display("FAIL b2b_drain got %0b exp 0", instr_valid); end
   endtask

   task automatic test_async_reset();
      PC = 32'h7000; im_ack = 1'b1;
      tick();
      im_ack = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h7777_0000;
      tick();
      im_rvalid = 1'b0; PC = 32'h7004; im_ack = 1'b1;
      tick();
      im_ack = 1'b0; PC = 32'h7008; #1;
      checks++; if (instr_valid !== 1'b1 || im_req !== 1'b0) begin errors++;
         $display("FAIL ar_pre got v=%0b req=%0b exp 1/0", instr_valid, im_req); end
      Reset = 1'b1; #1;
      checks++; if (instr_valid !== 1'b0 || im_req !== 1'b0 || pc_hold !== 1'b1) begin
         errors++;
         $display("FAIL ar_async got v=%0b req=%0b hold=%0b exp 0/0/1",
                  instr_valid, im_req, pc_hold); end
      PC = RPC; #1;
      Reset = 1'b0;
      tick();
      im_rvalid = 1'b1; im_rdata = 32'hBAD0_BAD0;
      tick();
      im_rvalid = 1'b0; #1;
      checks++; if (instr_valid !== 1'b0) begin errors++;
         $display("FAIL ar_stale got %0b exp 0", instr_valid); end
      checks++; if (im_req !== 1'b1 || im_addr !== 32'h3000) begin errors++;
         $display("FAIL ar_first_req got %0b %h exp 1 3000", im_req, im_addr); end
      im_ack = 1'b1;
      tick();
      im_ack = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h6060_6060;
      tick();
      im_rvalid = 1'b0; #1;
      checks++; if (instr_pc !== 32'h3000 || instr !== 32'h6060_6060) begin errors++;
         $display("FAIL ar_refetch got %h/%h exp 3000/60606060", instr_pc, instr); end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_full_queue();
      test_flush_wait();
      test_flush_rvalid();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
